tristate_bus_reader: RTL
========================

# tristate_bus_reader

Bus master that reads one word at a time from a bank of tri-state-output registers sharing a single data bus. It accepts a read request by register index, drives that register's active-low output select, waits a settle interval, captures the bus and returns the word on a valid/ready response channel. It sits between the CPU-side read logic and the register bank, guaranteeing that at most one register drives the shared bus at any time.

## Interface
- NrOfBits, 32, data width of bus and response
- NrOfRegs, 8, number of registers on the bus (2..32)
- IndexBits, 5, width of req_index
- SettleCycles, 1, Tick-qualified cycles a select is held before capture (>=1)

- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- Tick  in  1  global advance enable; all state updates qualified by Tick
- req_valid  in  1  read request present
- req_ready  out  1  request accepted when valid&ready&Tick at rising edge
- req_index  in  IndexBits  register to read
- cs_n  out  NrOfRegs  per-register select, active-low; 1 = register output floats
- bus_in  in  NrOfBits  shared tri-state data bus
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumed when valid&ready&Tick at rising edge
- rsp_data  out  NrOfBits  captured word
- rsp_err  out  1  index out of range, or sample mismatch (see Configuration)

## Operation
- Reset values: state IDLE, cs_n all ones, req_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0, settle count 0.
- States: IDLE, DRIVE, RESPOND.
- IDLE: req_ready=1. On accept with req_index<NrOfRegs: latch index, load count, go DRIVE. On accept with req_index>=NrOfRegs: no select asserted, rsp_data=0, rsp_err=1, go RESPOND.
- DRIVE: req_ready=0; cs_n[index]=0, all other bits 1. Count decrements per Tick; on the final Tick, bus_in captured into rsp_data, rsp_err=0, go RESPOND.
- RESPOND: cs_n all ones, rsp_valid=1, rsp_data/rsp_err stable. On rsp handshake go IDLE.
- Tick=0: no state, count, or output changes; handshakes not taken.
- cs_n is a registered output: at most one bit low at any time, never glitching.
- Index compare is unsigned, full IndexBits width.

## Timing
- Request accepted at edge E0; cs_n[index] low from E0 through E(SettleCycles) (Tick every cycle); capture and deassert at E(SettleCycles); rsp_valid high from E(SettleCycles) onward.
- Minimum accept-to-response latency SettleCycles+1 cycles; out-of-range requests 1 cycle.
- At least one cycle with all cs_n high between successive selects (RESPOND always lasts >=1 cycle).
- No new request accepted before rsp handshake; peak throughput one read per SettleCycles+2 cycles.
- Reset asserted mid-DRIVE: cs_n returns all ones immediately (asynchronous), pending request and response discarded.

## Configuration
- BUS_DOUBLE_SAMPLE_EN defined: DRIVE lasts SettleCycles+1 Ticks; bus sampled on the last two Ticks; rsp_data = second sample; rsp_err=1 if samples differ. Latency +1.
- Not defined: single sample as above; rsp_err only reports out-of-range index.

## Structure
- Shared package: state enum (IDLE, DRIVE, RESPOND), CS_IDLE all-ones constant helper, default width constants.
- One sub-module natural: tristate_bus_reader_settle_counter (loadable down-counter with Tick enable and terminal flag).

## Test plan
- Reset, SettleCycles=1, bus register 3 holds 0xDEADBEEF, request index 3 -> cs_n=0xF7 for 1 cycle, rsp_valid 2 cycles after accept, rsp_data 0xDEADBEEF, rsp_err 0.
- Request index 9 with NrOfRegs=8 -> cs_n stays 0xFF, rsp_valid next cycle, rsp_data 0, rsp_err 1.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready 0, cs_n 0xFF throughout; back-to-back reads show >=1 all-ones cs_n cycle.
- Tick toggled 1/0 each cycle during DRIVE with SettleCycles=3 -> select held 6 clocks, capture only on Tick=1 edges.
- Reset pulsed while cs_n=0xFE -> cs_n 0xFF before next clock edge, rsp_valid 0, req_ready 1.
- With BUS_DOUBLE_SAMPLE_EN, bus changes 0x1->0x2 between samples -> rsp_data 0x2, rsp_err 1.

Source files
------------

// File: rtl/tristate_bus_reader_pkg.sv
// Shared types and constants for the tri-state bus reader.
package tristate_bus_reader_pkg;

  localparam int unsigned DefNrOfBits     = 32;
  localparam int unsigned DefNrOfRegs     = 8;
  localparam int unsigned DefIndexBits    = 5;
  localparam int unsigned DefSettleCycles = 1;
  localparam int unsigned MaxNrOfRegs     = 32;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StRespond
  } state_e;

  // All selects deasserted; callers truncate to their register count.
  function automatic logic [MaxNrOfRegs-1:0] cs_idle();
    return '1;
  endfunction

endpackage

// File: rtl/tristate_bus_reader_settle_counter.sv
// Loadable down-counter with Tick enable; terminal flags the last count.
module tristate_bus_reader_settle_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Tick,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             dec_i,
  output logic             terminal_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: load wins over decrement; both wait for Tick.
  always_comb begin
    count_d = count_q;
    if (Tick) begin
      if (load_i) begin
        count_d = load_value_i;
      end else if (dec_i && (count_q != '0)) begin
        count_d = count_q - Width'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == Width'(1));

endmodule

// File: rtl/tristate_bus_reader.sv
// Reads one register at a time from a shared tri-state bus.
// Optional BUS_DOUBLE_SAMPLE_EN: hold select one extra Tick and compare two samples.
module tristate_bus_reader
  import tristate_bus_reader_pkg::*;
#(
  parameter int unsigned NrOfBits     = DefNrOfBits,
  parameter int unsigned NrOfRegs     = DefNrOfRegs,
  parameter int unsigned IndexBits    = DefIndexBits,
  parameter int unsigned SettleCycles = DefSettleCycles
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IndexBits-1:0] req_index,
  output logic [NrOfRegs-1:0]  cs_n,
  input  logic [NrOfBits-1:0]  bus_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NrOfBits-1:0]  rsp_data,
  output logic                 rsp_err
);

`ifdef BUS_DOUBLE_SAMPLE_EN
  localparam int unsigned DriveTicks = SettleCycles + 1;
`else
  localparam int unsigned DriveTicks = SettleCycles;
`endif
  localparam int unsigned CntW = $clog2(DriveTicks + 1);
  localparam logic [NrOfRegs-1:0] CsIdle = NrOfRegs'(cs_idle());

  state_e               state_q, state_d;
  logic [NrOfRegs-1:0]  cs_n_q, cs_n_d;
  logic [NrOfBits-1:0]  rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [NrOfRegs-1:0]  sel_dec;
  logic                 in_range;
  logic                 cnt_load, cnt_dec, cnt_terminal;
  logic                 mismatch;

  assign in_range = (32'(req_index) < NrOfRegs);

  // One-hot-low decode of the requested index.
  always_comb begin
    sel_dec = CsIdle;
    for (int unsigned i = 0; i < NrOfRegs; i++) begin
      sel_dec[i] = (32'(req_index) != i);
    end
  end

`ifdef BUS_DOUBLE_SAMPLE_EN
  logic [NrOfBits-1:0] sample_q, sample_d;

  // Keep the previous drive-phase sample so the final Tick can compare against it.
  always_comb begin
    sample_d = sample_q;
    if ((state_q == StDrive) && Tick) begin
      sample_d = bus_in;
    end
  end

  // Sample register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign mismatch = (bus_in != sample_q);
`else
  assign mismatch = 1'b0;
`endif

  // Next-state, select and response logic.
  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (Tick && req_valid) begin
          if (in_range) begin
            cs_n_d   = sel_dec;
            cnt_load = 1'b1;
            state_d  = StDrive;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = StRespond;
          end
        end
      end
      StDrive: begin
        cnt_dec = 1'b1;
        if (Tick && cnt_terminal) begin
          cs_n_d     = CsIdle;
          rsp_data_d = bus_in;
          rsp_err_d  = mismatch;
          state_d    = StRespond;
        end
      end
      StRespond: begin
        rsp_valid = 1'b1;
        if (Tick && rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        cs_n_d  = CsIdle;
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset floats every register immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      cs_n_q     <= CsIdle;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  tristate_bus_reader_settle_counter #(
    .Width (CntW)
  ) u_settle_counter (
    .Clock        (Clock),
    .Reset        (Reset),
    .Tick         (Tick),
    .load_i       (cnt_load),
    .load_value_i (CntW'(DriveTicks)),
    .dec_i        (cnt_dec),
    .terminal_o   (cnt_terminal)
  );

  assign cs_n     = cs_n_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule
